// File: rtl/goe_pkg.sv
// Shared definitions for the goe output engine: word header codes, PHV field
// positions, localbus register map and the transmit FSM state encoding.
package goe_pkg;

  localparam int WORD_W = 134;
  localparam int PHV_W  = 1024;

  // Word header codes in bits [133:132]
  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID  = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  // PHV field positions
  localparam int PHV_DROP_BIT = 1023;
  localparam int PHV_PORT_LSB = 1008;

  // Output-port byte position inside the head (metadata) word
  localparam int META_PORT_LSB = 120;

  // Localbus register byte addresses
  localparam logic [15:0] ADDR_SENT = 16'h0000;
  localparam logic [15:0] ADDR_DROP = 16'h0004;
  localparam logic [15:0] ADDR_ERR  = 16'h0008;
  localparam logic [15:0] ADDR_CTRL = 16'h000C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DROP  = 2'd2,
    ST_FLUSH = 2'd3
  } goe_state_e;

  // Header code of a packet word
  function automatic logic [1:0] hdr_code(input logic [WORD_W-1:0] w);
    return w[133:132];
  endfunction

endpackage

// File: rtl/goe_sfifo.sv
// First-word-fall-through synchronous FIFO with fill count. A write while full
// is discarded and flagged on overflow, unless a pop happens in the same cycle,
// in which case the write is accepted.
module goe_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             rd_ok;
  logic             wr_ok;

  assign rd_ok    = rd && (count_reg != '0);
  assign wr_ok    = wr && ((count_reg != FULL_CNT) || rd_ok);
  assign overflow = wr && !wr_ok;
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign rdata    = mem[rd_ptr_reg];

  // Storage array; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointer and fill-count bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (wr_ok && !rd_ok) begin
        count_reg <= count_reg + (AW+1)'(1);
      end else if (!wr_ok && rd_ok) begin
        count_reg <= count_reg - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/goe.sv
// goe: pairs each PHV with its packet, rewrites the output-port byte of the
// head word, drops flagged packets, counts traffic and errors on the localbus
// and passes the configuration chain through with one cycle of latency.
module goe
  import goe_pkg::*;
#(
  parameter logic [7:0] LMID        = 8'd7,
  parameter int         DATA_DEPTH  = 256,
  parameter int         PHV_DEPTH   = 16,
  parameter int         DATA_ALF_TH = 224,
  parameter int         PHV_ALF_TH  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_goe_data_wr,
  input  logic [133:0]       in_goe_data,
  input  logic               in_goe_valid_wr,
  input  logic               in_goe_valid,
  output logic               out_goe_data_alf,
  input  logic               in_goe_phv_wr,
  input  logic [1023:0]      in_goe_phv,
  output logic               out_goe_phv_alf,
  output logic               out_goe_data_wr,
  output logic [133:0]       out_goe_data,
  output logic               out_goe_valid_wr,
  output logic               out_goe_valid,
  input  logic               in_goe_alf,
  input  logic               cfg2goe_cs,
  input  logic               cfg2goe_rw,
  input  logic [15:0]        cfg2goe_addr,
  input  logic [31:0]        cfg2goe_wdata,
  output logic               goe2cfg_ack,
  output logic [31:0]        goe2cfg_rdata,
  input  logic [133:0]       cin_goe_data,
  input  logic               cin_goe_data_wr,
  output logic               cout_goe_ready,
  output logic [133:0]       cout_goe_data,
  output logic               cout_goe_data_wr,
  input  logic               cin_goe_ready
);

  localparam int DCW = $clog2(DATA_DEPTH) + 1;
  localparam int PCW = $clog2(PHV_DEPTH) + 1;

  // FIFO side
  logic [WORD_W:0]   df_q;
  logic              df_empty;
  logic              df_ovf;
  logic [DCW-1:0]    df_count;
  logic [PHV_W-1:0]  pf_q;
  logic              pf_empty;
  logic              pf_ovf;
  logic [PCW-1:0]    pf_count;

  // FSM
  goe_state_e        state_reg;
  goe_state_e        state_next;
  logic              data_pop;
  logic              phv_pop;
  logic              tx_word;
  logic              sent_inc;
  logic              drop_inc;
  logic              flush_err;
  logic [1:0]        df_code;
  logic [WORD_W-1:0] tx_data;

  // Transmit output registers
  logic              out_data_wr_reg;
  logic [WORD_W-1:0] out_data_reg;
  logic              out_valid_wr_reg;
  logic              out_valid_reg;
  logic              data_alf_reg;
  logic              phv_alf_reg;

  // Localbus and counters
  logic              cs_d_reg;
  logic              bus_req;
  logic              bus_wr;
  logic              ack_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       rd_mux;
  logic [31:0]       sent_reg;
  logic [31:0]       drop_reg;
  logic [31:0]       err_reg;
  logic [31:0]       ctrl_reg;
  logic [1:0]        err_add;

  // Config chain
  logic [WORD_W-1:0] cout_data_reg;
  logic              cout_wr_reg;
  logic              cc_consume_reg;
  logic              cin_is_head;
  logic              cin_drop;

  // Only the drop flag and port byte of the PHV are consumed here
  logic              unused_phv;
  assign unused_phv = ^{pf_q[PHV_DROP_BIT-1:PHV_PORT_LSB+8], pf_q[PHV_PORT_LSB-1:0]};

  goe_sfifo #(.WIDTH(WORD_W + 1), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (in_goe_data_wr),
    .wdata    ({in_goe_valid, in_goe_data}),
    .rd       (data_pop),
    .rdata    (df_q),
    .empty    (df_empty),
    .count    (df_count),
    .overflow (df_ovf)
  );

  goe_sfifo #(.WIDTH(PHV_W), .DEPTH(PHV_DEPTH)) u_phv_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (in_goe_phv_wr),
    .wdata    (in_goe_phv),
    .rd       (phv_pop),
    .rdata    (pf_q),
    .empty    (pf_empty),
    .count    (pf_count),
    .overflow (pf_ovf)
  );

  assign df_code = hdr_code(df_q[WORD_W-1:0]);

  // Head word gets the PHV port unless rewrite bypass is set
  assign tx_data = ((df_code == HDR_HEAD) && !ctrl_reg[0])
                 ? {df_q[133:128], pf_q[PHV_PORT_LSB +: 8], df_q[META_PORT_LSB-1:0]}
                 : df_q[WORD_W-1:0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state and pop/count strobes; downstream alf only gates packet start
  always_comb begin
    state_next = state_reg;
    data_pop   = 1'b0;
    phv_pop    = 1'b0;
    tx_word    = 1'b0;
    sent_inc   = 1'b0;
    drop_inc   = 1'b0;
    flush_err  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!df_empty) begin
          if (df_code != HDR_HEAD) begin
            state_next = ST_FLUSH;
          end else if (!pf_empty) begin
            if (pf_q[PHV_DROP_BIT]) begin
              state_next = ST_DROP;
            end else if (!in_goe_alf) begin
              state_next = ST_SEND;
            end
          end
        end
      end
      ST_FLUSH: begin
        data_pop   = !df_empty;
        flush_err  = !df_empty;
        state_next = ST_IDLE;
      end
      ST_SEND, ST_DROP: begin
        if (!df_empty) begin
          data_pop = 1'b1;
          tx_word  = (state_reg == ST_SEND);
          if (df_code == HDR_TAIL) begin
            phv_pop    = 1'b1;
            state_next = ST_IDLE;
            sent_inc   = (state_reg == ST_SEND);
            drop_inc   = (state_reg == ST_DROP);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Transmit registers and registered almost-full flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_wr_reg  <= 1'b0;
      out_data_reg     <= '0;
      out_valid_wr_reg <= 1'b0;
      out_valid_reg    <= 1'b0;
      data_alf_reg     <= 1'b0;
      phv_alf_reg      <= 1'b0;
    end else begin
      out_data_wr_reg  <= tx_word;
      out_data_reg     <= tx_word ? tx_data : '0;
      out_valid_wr_reg <= tx_word && (df_code == HDR_TAIL);
      out_valid_reg    <= tx_word && (df_code == HDR_TAIL) && df_q[WORD_W];
      data_alf_reg     <= (df_count >= DCW'(DATA_ALF_TH));
      phv_alf_reg      <= (pf_count >= PCW'(PHV_ALF_TH));
    end
  end

  assign out_goe_data_wr  = out_data_wr_reg;
  assign out_goe_data     = out_data_reg;
  assign out_goe_valid_wr = out_valid_wr_reg;
  assign out_goe_valid    = out_valid_reg;
  assign out_goe_data_alf = data_alf_reg;
  assign out_goe_phv_alf  = phv_alf_reg;

  // A request is the rising edge of cs; it is answered on the next cycle
  assign bus_req = cfg2goe_cs && !cs_d_reg;
  assign bus_wr  = bus_req && !cfg2goe_rw;
  assign err_add = {1'b0, flush_err} + {1'b0, df_ovf} + {1'b0, pf_ovf};

  // Register read multiplexer
  always_comb begin
    rd_mux = '0;
    case (cfg2goe_addr)
      ADDR_SENT: rd_mux = sent_reg;
      ADDR_DROP: rd_mux = drop_reg;
      ADDR_ERR:  rd_mux = err_reg;
      ADDR_CTRL: rd_mux = ctrl_reg;
      default:   rd_mux = '0;
    endcase
  end

  // Counters, control register and bus response; a clear beats an increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_d_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
      sent_reg  <= '0;
      drop_reg  <= '0;
      err_reg   <= '0;
      ctrl_reg  <= '0;
    end else begin
      cs_d_reg  <= cfg2goe_cs;
      ack_reg   <= bus_req;
      rdata_reg <= (bus_req && cfg2goe_rw) ? rd_mux : '0;

      if (bus_wr && (cfg2goe_addr == ADDR_SENT)) begin
        sent_reg <= '0;
      end else if (sent_inc) begin
        sent_reg <= sent_reg + 32'd1;
      end

      if (bus_wr && (cfg2goe_addr == ADDR_DROP)) begin
        drop_reg <= '0;
      end else if (drop_inc) begin
        drop_reg <= drop_reg + 32'd1;
      end

      if (bus_wr && (cfg2goe_addr == ADDR_ERR)) begin
        err_reg <= '0;
      end else begin
        err_reg <= err_reg + {30'd0, err_add};
      end

      if (bus_wr && (cfg2goe_addr == ADDR_CTRL)) begin
        ctrl_reg <= cfg2goe_wdata;
      end
    end
  end

  assign goe2cfg_ack   = ack_reg;
  assign goe2cfg_rdata = rdata_reg;

  // Packets addressed to this module are consumed for their whole length
  assign cin_is_head = (hdr_code(cin_goe_data) == HDR_HEAD);
  assign cin_drop    = cin_is_head ? (cin_goe_data[META_PORT_LSB +: 8] == LMID) : cc_consume_reg;

  // Config chain pass-through register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cout_data_reg  <= '0;
      cout_wr_reg    <= 1'b0;
      cc_consume_reg <= 1'b0;
    end else begin
      cout_data_reg <= cin_goe_data;
      cout_wr_reg   <= cin_goe_data_wr && !cin_drop;
      if (cin_goe_data_wr && cin_is_head) begin
        cc_consume_reg <= (cin_goe_data[META_PORT_LSB +: 8] == LMID);
      end
    end
  end

  assign cout_goe_data    = cout_data_reg;
  assign cout_goe_data_wr = cout_wr_reg;
  assign cout_goe_ready   = cin_goe_ready;

endmodule

// File: tb/tb_goe.sv
// Self-checking bench for goe: directed steps plus randomized packets checked
// against a packet-level reference model (expected output word queue and
// expected counter values).
module tb_goe;

  localparam logic [1:0] C_HEAD = 2'b01;
  localparam logic [1:0] C_MID  = 2'b11;
  localparam logic [1:0] C_TAIL = 2'b10;
  localparam logic [7:0] TB_LMID = 8'd7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_goe_data_wr;
  logic [133:0]  in_goe_data;
  logic          in_goe_valid_wr;
  logic          in_goe_valid;
  logic          out_goe_data_alf;
  logic          in_goe_phv_wr;
  logic [1023:0] in_goe_phv;
  logic          out_goe_phv_alf;
  logic          out_goe_data_wr;
  logic [133:0]  out_goe_data;
  logic          out_goe_valid_wr;
  logic          out_goe_valid;
  logic          in_goe_alf;
  logic          cfg2goe_cs;
  logic          cfg2goe_rw;
  logic [15:0]   cfg2goe_addr;
  logic [31:0]   cfg2goe_wdata;
  logic          goe2cfg_ack;
  logic [31:0]   goe2cfg_rdata;
  logic [133:0]  cin_goe_data;
  logic          cin_goe_data_wr;
  logic          cout_goe_ready;
  logic [133:0]  cout_goe_data;
  logic          cout_goe_data_wr;
  logic          cin_goe_ready;

  always #5 clk = ~clk;

  goe dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_goe_data_wr   (in_goe_data_wr),
    .in_goe_data      (in_goe_data),
    .in_goe_valid_wr  (in_goe_valid_wr),
    .in_goe_valid     (in_goe_valid),
    .out_goe_data_alf (out_goe_data_alf),
    .in_goe_phv_wr    (in_goe_phv_wr),
    .in_goe_phv       (in_goe_phv),
    .out_goe_phv_alf  (out_goe_phv_alf),
    .out_goe_data_wr  (out_goe_data_wr),
    .out_goe_data     (out_goe_data),
    .out_goe_valid_wr (out_goe_valid_wr),
    .out_goe_valid    (out_goe_valid),
    .in_goe_alf       (in_goe_alf),
    .cfg2goe_cs       (cfg2goe_cs),
    .cfg2goe_rw       (cfg2goe_rw),
    .cfg2goe_addr     (cfg2goe_addr),
    .cfg2goe_wdata    (cfg2goe_wdata),
    .goe2cfg_ack      (goe2cfg_ack),
    .goe2cfg_rdata    (goe2cfg_rdata),
    .cin_goe_data     (cin_goe_data),
    .cin_goe_data_wr  (cin_goe_data_wr),
    .cout_goe_ready   (cout_goe_ready),
    .cout_goe_data    (cout_goe_data),
    .cout_goe_data_wr (cout_goe_data_wr),
    .cin_goe_ready    (cin_goe_ready)
  );

  // Edge counter and output monitor
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic [135:0] got_mem  [4096];
  int           got_edge [4096];
  int           got_cnt   = 0;
  int           stray_vwr = 0;

  always @(negedge clk) begin
    if (out_goe_data_wr) begin
      got_mem[got_cnt]  <= {out_goe_valid_wr, out_goe_valid, out_goe_data};
      got_edge[got_cnt] <= edge_cnt;
      got_cnt           <= got_cnt + 1;
    end else if (out_goe_valid_wr) begin
      stray_vwr <= stray_vwr + 1;
    end
  end

  // Reference model state
  int           n_assert = 0;
  int           n_fail   = 0;
  int           sent_m   = 0;
  int           drop_m   = 0;
  int           err_m    = 0;
  logic         bypass_m = 1'b0;
  logic [135:0] exp_q [$];
  int           rd_idx    = 0;
  int           head_edge = 0;
  logic         rand_alf  = 1'b0;
  logic         fill_chk  = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one packet (PHV with the head word); model pushes what must emerge
  task automatic send_pkt(input int n, input logic [7:0] port, input logic drp,
                          input logic good, input logic partial);
    logic [133:0]  w;
    logic [1:0]    code;
    logic [1023:0] phv;
    logic [127:0]  pl;
    logic          last;
    for (int k = 0; k < 32; k++) phv[k*32 +: 32] = $urandom();
    phv[1023] = drp;
    phv[1015:1008] = port;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1) && !partial;
      code = (i == 0) ? C_HEAD : (last ? C_TAIL : C_MID);
      pl = rnd128();
      if (i == 0) pl[127:120] = port ^ 8'h5A;
      w = {code, 4'($urandom_range(0, 15)), pl};
      in_goe_data     = w;
      in_goe_data_wr  = 1'b1;
      in_goe_valid_wr = last;
      in_goe_valid    = last ? good : 1'b0;
      in_goe_phv_wr   = (i == 0);
      in_goe_phv      = phv;
      if (rand_alf) in_goe_alf = ($urandom_range(0, 3) == 0);
      if (!drp) begin
        if (i == 0 && !bypass_m) pl[127:120] = port;
        exp_q.push_back({last, last && good, code, w[131:128], pl});
      end
      tick();
      if (i == 0) head_edge = edge_cnt;
      if (fill_chk && i == 223) chk("data_alf_at_th", 136'(out_goe_data_alf), 136'(0));
      if (fill_chk && i == 224) chk("data_alf_after_th", 136'(out_goe_data_alf), 136'(1));
    end
    in_goe_data_wr  = 1'b0;
    in_goe_valid_wr = 1'b0;
    in_goe_valid    = 1'b0;
    in_goe_phv_wr   = 1'b0;
    if (rand_alf) in_goe_alf = 1'b0;
    if (!partial) begin
      if (drp) drop_m++;
      else sent_m++;
    end
  endtask

  // Wait (bounded) for the expected words, then compare count and contents
  task automatic drain_check(input string tag);
    int budget;
    budget = 0;
    while ((got_cnt - rd_idx) < exp_q.size() && budget < 2000) begin
      tick();
      budget++;
    end
    repeat (4) tick();
    chk({tag, "_count"}, 136'(got_cnt - rd_idx), 136'(exp_q.size()));
    while (exp_q.size() > 0 && rd_idx < got_cnt) begin
      chk({tag, "_word"}, got_mem[rd_idx], exp_q.pop_front());
      rd_idx++;
    end
    rd_idx = got_cnt;
    exp_q.delete();
  endtask

  task automatic reg_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        ack1;
    logic        ack2;
    cfg2goe_cs = 1'b1; cfg2goe_rw = 1'b1; cfg2goe_addr = a;
    tick();
    d = goe2cfg_rdata; ack1 = goe2cfg_ack;
    cfg2goe_cs = 1'b0;
    tick();
    ack2 = goe2cfg_ack;
    chk({tag, "_ack"}, 136'(ack1), 136'(1));
    chk({tag, "_ackpulse"}, 136'(ack2), 136'(0));
    chk(tag, 136'(d), 136'(exp));
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    cfg2goe_cs = 1'b1; cfg2goe_rw = 1'b0; cfg2goe_addr = a; cfg2goe_wdata = d;
    tick();
    cfg2goe_cs = 1'b0;
    tick();
  endtask

  task automatic cfg_pkt(input logic [7:0] dst, input int n);
    logic [133:0] w;
    logic [127:0] pl;
    logic         fwd;
    fwd = (dst != TB_LMID);
    for (int i = 0; i < n; i++) begin
      pl = rnd128();
      if (i == 0) pl[127:120] = dst;
      w = {(i == 0) ? C_HEAD : ((i == n - 1) ? C_TAIL : C_MID), 4'd0, pl};
      cin_goe_data = w; cin_goe_data_wr = 1'b1;
      tick();
      chk("cfg_wr", 136'(cout_goe_data_wr), 136'(fwd));
      if (fwd) chk("cfg_data", 136'(cout_goe_data), 136'(w));
    end
    cin_goe_data_wr = 1'b0;
    tick();
    chk("cfg_idle", 136'(cout_goe_data_wr), 136'(0));
  endtask

  task automatic check_counters(input string tag);
    reg_check({tag, "_sent"}, 16'h0000, 32'(sent_m));
    reg_check({tag, "_drop"}, 16'h0004, 32'(drop_m));
    reg_check({tag, "_err"},  16'h0008, 32'(err_m));
  endtask

  initial begin
    int first;
    int rel;
    rst_n = 1'b0;
    in_goe_data_wr = 1'b0; in_goe_data = '0; in_goe_valid_wr = 1'b0; in_goe_valid = 1'b0;
    in_goe_phv_wr = 1'b0; in_goe_phv = '0; in_goe_alf = 1'b0;
    cfg2goe_cs = 1'b0; cfg2goe_rw = 1'b0; cfg2goe_addr = '0; cfg2goe_wdata = '0;
    cin_goe_data = '0; cin_goe_data_wr = 1'b0; cin_goe_ready = 1'b1;

    // Step 1: reset state
    repeat (3) tick();
    chk("rst_data_wr",  136'(out_goe_data_wr), 136'(0));
    chk("rst_data",     136'(out_goe_data), 136'(0));
    chk("rst_valid_wr", 136'(out_goe_valid_wr), 136'(0));
    chk("rst_data_alf", 136'(out_goe_data_alf), 136'(0));
    chk("rst_phv_alf",  136'(out_goe_phv_alf), 136'(0));
    chk("rst_ack",      136'(goe2cfg_ack), 136'(0));
    chk("rst_cout_wr",  136'(cout_goe_data_wr), 136'(0));
    rst_n = 1'b1;
    tick();
    check_counters("rst");
    reg_check("rst_ctrl", 16'h000C, 32'd0);

    // Step 2: basic 3-word packet to port 0x05
    first = got_cnt;
    send_pkt(3, 8'h05, 1'b0, 1'b1, 1'b0);
    drain_check("basic");
    chk("basic_latency", 136'(got_edge[first] - head_edge), 136'(2));
    reg_check("basic_sent", 16'h0000, 32'(sent_m));

    // Step 3: dropped packet, then a normal packet at nominal latency
    send_pkt(4, 8'h21, 1'b1, 1'b1, 1'b0);
    drain_check("drop");
    reg_check("drop_cnt", 16'h0004, 32'(drop_m));
    first = got_cnt;
    send_pkt(3, 8'h33, 1'b0, 1'b0, 1'b0);
    drain_check("after_drop");
    chk("after_drop_latency", 136'(got_edge[first] - head_edge), 136'(2));
    reg_check("sent_two", 16'h0000, 32'd2);
    bus_write(16'h0000, 32'hFFFF_FFFF);
    sent_m = 0;
    reg_check("sent_clr", 16'h0000, 32'(sent_m));

    // Step 4: downstream alf holds a ready packet
    in_goe_alf = 1'b1;
    first = got_cnt;
    send_pkt(3, 8'h44, 1'b0, 1'b1, 1'b0);
    repeat (8) tick();
    chk("alf_hold", 136'(got_cnt - first), 136'(0));
    in_goe_alf = 1'b0;
    rel = edge_cnt;
    drain_check("alf_release");
    chk("alf_latency", 136'(got_edge[first] - rel), 136'(2));

    // Step 5: alf raised mid-packet does not stall it
    first = got_cnt;
    send_pkt(6, 8'h55, 1'b0, 1'b1, 1'b0);
    in_goe_alf = 1'b1;
    drain_check("alf_mid");
    chk("alf_mid_span", 136'(got_edge[first + 5] - got_edge[first]), 136'(5));
    in_goe_alf = 1'b0;

    // Step 6: orphan middle word is flushed
    in_goe_data = {C_MID, 4'd0, rnd128()}; in_goe_data_wr = 1'b1;
    tick();
    in_goe_data_wr = 1'b0;
    err_m++;
    drain_check("flush");
    reg_check("flush_err", 16'h0008, 32'(err_m));

    // Step 7: fill to almost-full and overflow, then drain intact
    in_goe_alf = 1'b1;
    fill_chk = 1'b1;
    send_pkt(256, 8'h66, 1'b0, 1'b1, 1'b0);
    fill_chk = 1'b0;
    in_goe_data = {C_MID, 4'd0, rnd128()}; in_goe_data_wr = 1'b1;
    tick();
    in_goe_data_wr = 1'b0;
    err_m++;
    chk("data_alf_full", 136'(out_goe_data_alf), 136'(1));
    reg_check("ovf_err", 16'h0008, 32'(err_m));
    in_goe_alf = 1'b0;
    drain_check("fill");

    // Step 8: rewrite bypass
    bus_write(16'h000C, 32'h0000_0001);
    reg_check("ctrl_rd", 16'h000C, 32'h0000_0001);
    bypass_m = 1'b1;
    send_pkt(3, 8'h77, 1'b0, 1'b1, 1'b0);
    drain_check("bypass");
    bus_write(16'h000C, 32'h0000_0000);
    bypass_m = 1'b0;

    // Step 9: unmapped address
    bus_write(16'h0010, 32'hDEAD_BEEF);
    reg_check("unmapped", 16'h0010, 32'd0);
    reg_check("ctrl_kept", 16'h000C, 32'd0);

    // Step 10: randomized packets with random downstream alf
    rand_alf = 1'b1;
    for (int p = 0; p < 24; p++) begin
      send_pkt($urandom_range(2, 8), 8'($urandom()), ($urandom_range(0, 3) == 0),
               1'($urandom()), 1'b0);
    end
    rand_alf = 1'b0;
    drain_check("random");
    check_counters("random");

    // Step 11: config chain
    cin_goe_ready = 1'b0;
    #1 chk("cout_ready_lo", 136'(cout_goe_ready), 136'(0));
    cin_goe_ready = 1'b1;
    #1 chk("cout_ready_hi", 136'(cout_goe_ready), 136'(1));
    cfg_pkt(8'h33, 3);
    cfg_pkt(TB_LMID, 3);
    cfg_pkt(8'h08, 2);

    // Step 12: reset mid-packet; remainder must be flushed, no tail emitted
    send_pkt(3, 8'h12, 1'b0, 1'b1, 1'b1);
    drain_check("partial");
    rst_n = 1'b0;
    tick();
    tick();
    chk("midrst_data_wr", 136'(out_goe_data_wr), 136'(0));
    chk("midrst_valid_wr", 136'(out_goe_valid_wr), 136'(0));
    rst_n = 1'b1;
    tick();
    sent_m = 0; drop_m = 0; err_m = 0; bypass_m = 1'b0;
    in_goe_data = {C_TAIL, 4'd0, rnd128()}; in_goe_data_wr = 1'b1;
    in_goe_valid_wr = 1'b1; in_goe_valid = 1'b1;
    tick();
    in_goe_data_wr = 1'b0; in_goe_valid_wr = 1'b0; in_goe_valid = 1'b0;
    err_m++;
    drain_check("post_rst");
    check_counters("post_rst");

    // Step 13: PHV almost-full threshold
    for (int i = 0; i < 12; i++) begin
      in_goe_phv_wr = 1'b1; in_goe_phv = {32{$urandom()}};
      tick();
    end
    in_goe_phv_wr = 1'b0;
    chk("phv_alf_at_th", 136'(out_goe_phv_alf), 136'(0));
    tick();
    chk("phv_alf_after_th", 136'(out_goe_phv_alf), 136'(1));

    chk("stray_valid_wr", 136'(stray_vwr), 136'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/goe.md
# goe

Output engine at the end of the FAST pipeline, directly downstream of `pgm`. It pairs each 1024-bit PHV from `pgm` with the matching 134-bit packet stream. It rewrites the output-port byte in the metadata word, drops packets whose PHV drop flag is set, and forwards everything else to the port-side transmit logic. It exposes packet and drop counters on the localbus and passes the configuration packet chain through.

## Interface
- `LMID`, 8'd7, own module ID; config packets with dst MID == `LMID` are consumed, not forwarded.
- `DATA_DEPTH`, 256, data FIFO depth in words (power of 2).
- `PHV_DEPTH`, 16, PHV FIFO depth (power of 2).
- `DATA_ALF_TH`, 224, data FIFO fill level at which `out_goe_data_alf` asserts.
- `PHV_ALF_TH`, 12, PHV FIFO fill level at which `out_goe_phv_alf` asserts.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_goe_data_wr` in 1 / `in_goe_data` in 134: packet words from `pgm`.
- `in_goe_valid_wr` in 1 / `in_goe_valid` in 1: end-of-packet strobe and packet-good flag, coincident with the tail word.
- `out_goe_data_alf` out 1: data FIFO fill level ≥ `DATA_ALF_TH`.
- `in_goe_phv_wr` in 1 / `in_goe_phv` in 1024: one PHV per packet.
- `out_goe_phv_alf` out 1: PHV FIFO fill level ≥ `PHV_ALF_TH`.
- `out_goe_data_wr` out 1 / `out_goe_data` out 134: transmitted words.
- `out_goe_valid_wr` out 1 / `out_goe_valid` out 1: end-of-packet strobe and good flag.
- `in_goe_alf` in 1: downstream almost full.
- `cfg2goe_cs` in 1, `cfg2goe_rw` in 1 (0 = write), `cfg2goe_addr` in 16, `cfg2goe_wdata` in 32: localbus request.
- `goe2cfg_ack` out 1, `goe2cfg_rdata` out 32: localbus response.
- `cin_goe_data` in 134, `cin_goe_data_wr` in 1, `cout_goe_ready` out 1: config chain input.
- `cout_goe_data` out 134, `cout_goe_data_wr` out 1, `cin_goe_ready` in 1: config chain output.

## Operation
- Word format:
  - [133:132]: 01 = head, 11 = middle, 10 = tail.
  - [131:128]: invalid byte count.
  - [127:0]: payload.
  - The head word carries metadata; its byte [127:120] is the output port.
- Data FIFO: 135 bits wide, written with `{in_goe_valid, in_goe_data}` on `in_goe_data_wr`. PHV FIFO: written on `in_goe_phv_wr`. Both FIFOs are first-word-fall-through.
- PHV fields:
  - [1023]: drop.
  - [1015:1008]: output port.
- FSM:
  - IDLE → SEND when PHV FIFO is non-empty, data FIFO is non-empty, head is a head word, drop = 0 and `in_goe_alf` = 0.
  - IDLE → DROP when the same conditions hold except drop = 1; `in_goe_alf` is ignored.
  - IDLE → FLUSH when data FIFO head is not a head word; the word is popped as an error.
  - SEND/DROP pop one word per cycle while the data FIFO is non-empty and stall while it is empty.
  - On the tail word, the PHV is popped and the FSM returns to IDLE.
- SEND behaviour:
  - Head word has [127:120] replaced by the PHV port unless `CTRL[0]` (rewrite bypass) = 1.
  - Tail word asserts `out_goe_valid_wr`, with `out_goe_valid` taken from the stored valid bit.
  - `in_goe_alf` is sampled only at packet start.
- Counters are 32 bits and wrap: `SENT` (tails in SEND), `DROP` (tails in DROP), `ERR` (flushed words plus overflow writes).
- Writes to a full FIFO are discarded and increment `ERR`.
- Registers (byte address):
  - 0x0000 `SENT`: read; any write clears it.
  - 0x0004 `DROP`: read; any write clears it.
  - 0x0008 `ERR`: read; any write clears it.
  - 0x000C `CTRL`: read/write.
  - Other addresses read 0; writes to them are ignored.
- Counter increment and clear in the same cycle: the clear wins.
- Config chain: input registered once, forwarded unless head word [127:120] == `LMID`. `cout_goe_ready` = `cin_goe_ready`.

## Timing
- Reset values: all outputs, counters and `CTRL` are 0; FSM is in IDLE; both FIFOs are empty.
- Reset mid-packet aborts the packet; downstream sees no tail.
- Latency: conditions true in cycle t → FSM leaves IDLE at t+1 with the first pop → `out_goe_data_wr` asserted at t+2. Steady state is 1 word per cycle.
- Simultaneous FIFO write and pop at full: the write is accepted.
- Alf outputs are registered from the fill count, 1 cycle after the threshold crossing.
- Localbus: `cs` rising edge seen in cycle t → `goe2cfg_ack` pulses for 1 cycle at t+1, with `goe2cfg_rdata` valid at t+1; the next request needs `cs` deasserted first.
- Config chain: 1-cycle latency.

## Structure
- `goe_pkg`: header codes, PHV bit positions, register addresses, FSM state enum.
- Sub-module `goe_sfifo`: width/depth-parameterised FWFT sync FIFO with fill count, instantiated twice.

## Test plan
- 3-word packet, PHV port 0x05, drop 0 → 3 output words, head [127:120] = 0x05, tail `valid_wr` = 1 with `valid` = 1, `SENT` = 1.
- PHV drop = 1, 4-word packet → no output, `DROP` = 1; a following normal packet emerges at its t+2 latency.
- `in_goe_alf` = 1 while a packet is ready → no output; after `alf` deasserts, first word appears 2 cycles later. `alf` asserted mid-packet does not stall the packet.
- Middle word arriving with no preceding head → flushed, `ERR` = 1, no output.
- Fill data FIFO to 224 → `out_goe_data_alf` = 1 one cycle later; overflow write at 256 words → `ERR` increments, FIFO contents intact.
- Read 0x0000 after 2 packets → rdata = 2 with ack at t+1; write 0x0000 → subsequent read = 0; `CTRL[0]` = 1 → head byte [127:120] passes unmodified.
